// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and a future matching receiver.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..ClksPerBit-1 while enabled, then wraps.
// bit_done_o marks the last cycle of a bit; bit_pre_done_o marks the cycle before it.
module uart_baud_cnt #(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_done_o,
    output logic bit_pre_done_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntLast    = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntPreLast = CntW'(ClksPerBit - 2);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable; wrap at the end of each bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o     = en_i && (cnt_q == CntLast);
    assign bit_pre_done_o = en_i && (cnt_q == CntPreLast);

endmodule

// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter, LSB first, 8N1/8N2 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1/8E2).
// tx, tx_ready and busy are all registered; back-to-back bytes leave no idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic accept;
    logic bit_done;
    logic bit_pre_done;
    logic last_stop;

    assign accept    = tx_valid && ready_q;
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt_q;

    uart_baud_cnt #(
        .ClksPerBit (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (state_q != StIdle),
        .clr_i          (accept),
        .bit_done_o     (bit_done),
        .bit_pre_done_o (bit_pre_done)
    );

    // Frame sequencing; line level is computed one cycle ahead so tx leaves a flop.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ready_d    = ready_q;

        unique case (state_q)
            StIdle: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    parity_d  = parity_q ^ shift_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = StParity;
                        tx_d       = parity_q;
`else
                        state_d    = StStop;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        parity_d  = parity_q ^ shift_q[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d    = StStop;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            StStop: begin
                // Open the handshake for exactly the final cycle of the final stop bit.
                if (bit_pre_done && last_stop) begin
                    ready_d = 1'b1;
                end
                if (bit_done) begin
                    if (last_stop) begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Acceptance overrides the return to idle so the next start bit follows directly.
        if (accept) begin
            state_d  = StStart;
            shift_d  = tx_data;
            parity_d = 1'b0;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;

endmodule
